// File: rtl/muldiv_unit.sv
// Iterative signed/unsigned multiply/divide engine with a start/done handshake.
// Retires STEPS_PER_CYCLE shift-add or restoring-subtract steps per clock; supports cancel.
module muldiv_unit #(
  parameter int unsigned WIDTH           = 32,
  parameter int unsigned STEPS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);

  localparam int unsigned W     = WIDTH;
  localparam int unsigned N     = WIDTH / STEPS_PER_CYCLE;
  localparam int unsigned CNT_W = $clog2(N + 1);

  typedef enum logic [1:0] {IDLE, PREP, RUN, FIN} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2*W-1:0]   acc_q, acc_d;
  logic [W-1:0]     sh_q, sh_d;
  logic [W-1:0]     opb_q, opb_d;
  logic [W-1:0]     a_q, a_d, b_q, b_d;
  logic [1:0]       op_q, op_d;
  logic             qneg_q, qneg_d, rneg_q, rneg_d;
  logic             busy_q, busy_d, done_q, done_d, dbz_q, dbz_d;
  logic [W-1:0]     hi_q, hi_d, lo_q, lo_d;

  logic [2*W-1:0]   acc_n, prod_t;
  logic [W-1:0]     sh_n, quot_t, rem_t, amag, bmag;
  logic [W:0]       r_t;
  logic             is_div, is_signed;

  assign is_div    = op_q[1];
  assign is_signed = !op_q[0];

  // One clock's worth of datapath steps; acc holds the product or (low W+1 bits) the remainder.
  always_comb begin
    acc_n = acc_q;
    sh_n  = sh_q;
    r_t   = '0;
    for (int s = 0; s < int'(STEPS_PER_CYCLE); s++) begin
      if (is_div) begin
        r_t  = {acc_n[W-1:0], sh_n[W-1]};
        sh_n = {sh_n[W-2:0], 1'b0};
        if (r_t >= {1'b0, opb_q}) begin
          r_t     = r_t - {1'b0, opb_q};
          sh_n[0] = 1'b1;
        end
        acc_n = {{(W-1){1'b0}}, r_t};
      end else begin
        acc_n = {acc_n[2*W-2:0], 1'b0} + (sh_n[W-1] ? {{W{1'b0}}, opb_q} : {(2*W){1'b0}});
        sh_n  = {sh_n[W-2:0], 1'b0};
      end
    end
  end

  // Operand magnitudes and sign-corrected results
  always_comb begin
    amag   = (is_signed && a_q[W-1]) ? (W'(0) - a_q) : a_q;
    bmag   = (is_signed && b_q[W-1]) ? (W'(0) - b_q) : b_q;
    prod_t = (is_signed && qneg_q) ? ((2*W)'(0) - acc_n) : acc_n;
    quot_t = (is_signed && qneg_q) ? (W'(0) - sh_n) : sh_n;
    rem_t  = (is_signed && rneg_q) ? (W'(0) - acc_n[W-1:0]) : acc_n[W-1:0];
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    sh_d    = sh_q;
    opb_d   = opb_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    done_d  = 1'b0;
    dbz_d   = dbz_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      IDLE: begin
        if (start && !cancel) begin
          a_d     = a;
          b_d     = b;
          op_d    = op;
          dbz_d   = 1'b0;
          state_d = PREP;
        end
      end
      PREP: begin
        if (cancel) begin
          state_d = IDLE;
        end else begin
          acc_d  = '0;
          cnt_d  = CNT_W'(N);
          qneg_d = a_q[W-1] ^ b_q[W-1];
          rneg_d = a_q[W-1];
          sh_d   = is_div ? amag : bmag;
          opb_d  = is_div ? bmag : amag;
          if (is_div && (b_q == '0)) begin
            state_d = FIN;
            hi_d    = a_q;
            lo_d    = '1;
            dbz_d   = 1'b1;
            done_d  = 1'b1;
          end else begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        if (cancel) begin
          state_d = IDLE;
        end else begin
          acc_d = acc_n;
          sh_d  = sh_n;
          if (cnt_q == CNT_W'(1)) begin
            // Results land as FIN is entered so they are valid alongside done.
            state_d = FIN;
            done_d  = 1'b1;
            hi_d    = is_div ? rem_t : prod_t[2*W-1:W];
            lo_d    = is_div ? quot_t : prod_t[W-1:0];
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      sh_q    <= '0;
      opb_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      sh_q    <= sh_d;
      opb_q   <= opb_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign hi          = hi_q;
  assign lo          = lo_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed-vector bench for muldiv_unit: three instances (W32/SPC1, W32/SPC2, W16/SPC4).
module tb_muldiv_unit;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        start0, cancel0, busy0, done0, dbz0;
  logic [1:0]  op0;
  logic [31:0] a0, b0, hi0, lo0;
  logic        start1, cancel1, busy1, done1, dbz1;
  logic [1:0]  op1;
  logic [31:0] a1, b1, hi1, lo1;
  logic        start2, cancel2, busy2, done2, dbz2;
  logic [1:0]  op2;
  logic [15:0] a2, b2, hi2, lo2;

  muldiv_unit #(.WIDTH(32), .STEPS_PER_CYCLE(1)) u_dut0 (
    .clk(clk), .reset(reset), .start(start0), .op(op0), .a(a0), .b(b0), .cancel(cancel0),
    .busy(busy0), .done(done0), .hi(hi0), .lo(lo0), .div_by_zero(dbz0));
  muldiv_unit #(.WIDTH(32), .STEPS_PER_CYCLE(2)) u_dut1 (
    .clk(clk), .reset(reset), .start(start1), .op(op1), .a(a1), .b(b1), .cancel(cancel1),
    .busy(busy1), .done(done1), .hi(hi1), .lo(lo1), .div_by_zero(dbz1));
  muldiv_unit #(.WIDTH(16), .STEPS_PER_CYCLE(4)) u_dut2 (
    .clk(clk), .reset(reset), .start(start2), .op(op2), .a(a2), .b(b2), .cancel(cancel2),
    .busy(busy2), .done(done2), .hi(hi2), .lo(lo2), .div_by_zero(dbz2));

  localparam logic [1:0] OP_MULT = 2'b00, OP_MULTU = 2'b01, OP_DIV = 2'b10, OP_DIVU = 2'b11;

  int n_chk = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic sel_busy(input int sel);
    return (sel == 0) ? busy0 : (sel == 1) ? busy1 : busy2;
  endfunction
  function automatic logic sel_done(input int sel);
    return (sel == 0) ? done0 : (sel == 1) ? done1 : done2;
  endfunction
  function automatic logic sel_dbz(input int sel);
    return (sel == 0) ? dbz0 : (sel == 1) ? dbz1 : dbz2;
  endfunction
  function automatic logic [63:0] sel_res(input int sel);
    return (sel == 0) ? {hi0, lo0} : (sel == 1) ? {hi1, lo1} : {16'h0, hi2, 16'h0, lo2};
  endfunction

  // Called just after an edge (cycle t); returns latency to done and whether busy held throughout.
  task automatic go(input int sel, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                    output int lat, output logic busy_ok, output logic dbz_at1);
    lat = -1;
    busy_ok = 1'b1;
    dbz_at1 = 1'b1;
    case (sel)
      0: begin op0 = op; a0 = a; b0 = b; start0 = 1'b1; end
      1: begin op1 = op; a1 = a; b1 = b; start1 = 1'b1; end
      default: begin op2 = op; a2 = a[15:0]; b2 = b[15:0]; start2 = 1'b1; end
    endcase
    for (int k = 1; k <= 100; k++) begin
      @(posedge clk); #1;
      if (k == 1) begin
        start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
        dbz_at1 = sel_dbz(sel);
      end
      if (!sel_busy(sel)) busy_ok = 1'b0;
      if (sel_done(sel)) begin
        lat = k;
        break;
      end
    end
    @(posedge clk); #1;
    if (sel_busy(sel) || sel_done(sel)) busy_ok = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, lat2, ndone;
    logic bok, d1;
    logic [63:0] saved;
    reset = 1'b1;
    {start0, cancel0, op0, a0, b0} = '0;
    {start1, cancel1, op1, a1, b1} = '0;
    {start2, cancel2, op2, a2, b2} = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_outs0", {busy0, done0, dbz0, hi0, lo0}, 64'h0);
    chk("rst_outs2", {busy2, done2, dbz2, hi2, lo2}, 64'h0);

    go(0, OP_MULT, 32'hFFFF_FFFD, 32'd7, lat, bok, d1);
    chk("mult_lat", 64'(lat), 64'd34);
    chk("mult_busy", {63'h0, bok}, 64'd1);
    chk("mult_res", sel_res(0), 64'hFFFF_FFFF_FFFF_FFEB);

    go(0, OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, bok, d1);
    chk("multu_res", sel_res(0), 64'hFFFF_FFFE_0000_0001);

    go(0, OP_DIVU, 32'd100, 32'd7, lat, bok, d1);
    chk("divu_res", sel_res(0), {32'd2, 32'd14});

    go(0, OP_DIV, 32'hFFFF_FFF9, 32'd2, lat, bok, d1);
    chk("div_neg_res", sel_res(0), 64'hFFFF_FFFF_FFFF_FFFD);

    go(0, OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, lat, bok, d1);
    chk("div_ovf_res", sel_res(0), 64'h0000_0000_8000_0000);
    chk("div_ovf_dbz", {63'h0, dbz0}, 64'd0);

    go(0, OP_DIVU, 32'd100, 32'd0, lat, bok, d1);
    chk("dbz_lat", 64'(lat), 64'd2);
    chk("dbz_flag", {63'h0, dbz0}, 64'd1);
    chk("dbz_res", sel_res(0), {32'd100, 32'hFFFF_FFFF});

    // cancel together with start in IDLE: start must be rejected
    op0 = OP_DIVU; a0 = 32'd9; b0 = 32'd3; start0 = 1'b1; cancel0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0; cancel0 = 1'b0;
    chk("idle_cancel_busy", {63'h0, busy0}, 64'd0);
    chk("idle_cancel_dbz", {63'h0, dbz0}, 64'd1);

    go(0, OP_DIVU, 32'd100, 32'd7, lat, bok, d1);
    chk("dbz_clear_t1", {63'h0, d1}, 64'd0);
    chk("dbz_clear_res", sel_res(0), {32'd2, 32'd14});

    // start while busy is ignored
    op0 = OP_MULTU; a0 = 32'd5; b0 = 32'd6; start0 = 1'b1;
    lat2 = -1;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk); #1;
      if (k == 1) start0 = 1'b0;
      if (k == 10) begin start0 = 1'b1; op0 = OP_DIV; a0 = 32'd9; b0 = 32'd0; end
      if (k == 11) start0 = 1'b0;
      if (done0 && lat2 < 0) lat2 = k;
      if (lat2 > 0 && k > lat2 + 2) break;
    end
    chk("busy_start_lat", 64'(lat2), 64'd34);
    chk("busy_start_res", sel_res(0), {32'd0, 32'd30});
    chk("busy_start_dbz", {63'h0, dbz0}, 64'd0);

    // cancel mid-run
    saved = sel_res(0);
    op0 = OP_MULT; a0 = 32'd7; b0 = 32'd7; start0 = 1'b1;
    ndone = 0;
    for (int k = 1; k <= 50; k++) begin
      @(posedge clk); #1;
      if (k == 1) start0 = 1'b0;
      if (k == 10) cancel0 = 1'b1;
      if (k == 11) begin
        cancel0 = 1'b0;
        chk("cancel_idle", {63'h0, busy0}, 64'd0);
      end
      if (done0) ndone++;
    end
    chk("cancel_no_done", 64'(ndone), 64'd0);
    chk("cancel_hold", sel_res(0), saved);

    // reset mid-run
    op0 = OP_MULTU; a0 = 32'd3; b0 = 32'd3; start0 = 1'b1;
    for (int k = 1; k <= 11; k++) begin
      @(posedge clk); #1;
      if (k == 1) start0 = 1'b0;
      if (k == 10) reset = 1'b1;
    end
    chk("midrst_outs", {busy0, done0, dbz0, hi0, lo0}, 64'h0);
    reset = 1'b0;

    go(1, OP_MULT, 32'd12345, 32'hFFFF_E57B, lat, bok, d1);
    chk("spc2_lat", 64'(lat), 64'd18);
    chk("spc2_res", sel_res(1), 64'hFFFF_FFFF_FB01_2863);

    go(2, OP_DIV, 32'h0000_FF9C, 32'd7, lat, bok, d1);
    chk("w16_lat", 64'(lat), 64'd6);
    chk("w16_busy", {63'h0, bok}, 64'd1);
    chk("w16_res", sel_res(2), 64'h0000_FFFE_0000_FFF2);

    go(2, OP_DIVU, 32'h0000_FFFF, 32'd0, lat, bok, d1);
    chk("w16_dbz", {63'h0, dbz2}, 64'd1);
    chk("w16_dbz_res", sel_res(2), 64'h0000_FFFF_0000_FFFF);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
